// File: rtl/write_dfx_data_pipe.sv
// Two-slot write unpacker between a lane's arbiter data FIFO and the write arbiter.
// Output slot feeds the arbiter; a prefetch slot keeps one transfer per granted cycle.
module write_dfx_data_pipe #(
    parameter int DATA_WIDTH     = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
    parameter int STALL_LIMIT    = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      empty_arbiter_fifo,
    input  logic [DATA_DFX_WIDTH-1:0] data_dfx_recv,
    output logic                      read_arbiter_fifo,
    input  logic                      arbiter_write_gnt,
    output logic                      arbiter_write_req,
    output logic [ADDR_WIDTH-1:0]     router_dst_addr_recv,
    output logic [DATA_WIDTH-1:0]     data_arbiter_recv,
    output logic                      stall_flag,
    output logic [CNT_WIDTH-1:0]      pkt_count
);

    localparam logic [31:0] LIMIT = STALL_LIMIT;

    logic                      out_vld, pf_vld, inflight;
    logic [DATA_DFX_WIDTH-1:0] out_word, pf_word;
    logic [CNT_WIDTH-1:0]      stall_cnt, stall_nxt;
    logic                      xfer, land;
    logic [2:0]                used;

    assign xfer = out_vld && arbiter_write_gnt;
    assign land = inflight && !flush;

    // Words held or owed after this cycle; a new read is only safe below two.
    assign used = 3'(out_vld) + 3'(pf_vld) + 3'(inflight) - 3'(xfer);
    assign read_arbiter_fifo = rst_n && !empty_arbiter_fifo && !flush && (used < 3'd2);

    // Output word is zeroed whenever the slot is invalid, so outputs need no gating.
    assign arbiter_write_req    = out_vld;
    assign router_dst_addr_recv = out_word[ADDR_WIDTH-1:0];
    assign data_arbiter_recv    = out_word[DATA_DFX_WIDTH-1:ADDR_WIDTH];

    always_comb begin
        stall_nxt = stall_cnt;
        if (flush || xfer)
            stall_nxt = '0;
        else if (out_vld && !arbiter_write_gnt && stall_cnt != '1)
            stall_nxt = stall_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_word   <= '0;
            pf_vld     <= 1'b0;
            pf_word    <= '0;
            inflight   <= 1'b0;
            stall_cnt  <= '0;
            stall_flag <= 1'b0;
            pkt_count  <= '0;
        end else begin
            pkt_count  <= pkt_count + CNT_WIDTH'(xfer);
            stall_cnt  <= stall_nxt;
            stall_flag <= (32'(stall_nxt) >= LIMIT);
            if (flush) begin
                out_vld  <= 1'b0;
                out_word <= '0;
                pf_vld   <= 1'b0;
                pf_word  <= '0;
                inflight <= 1'b0;
            end else begin
                inflight <= read_arbiter_fifo;
                if (!out_vld || xfer) begin
                    // Output slot frees up: oldest word (prefetch first) moves in.
                    if (pf_vld) begin
                        out_vld  <= 1'b1;
                        out_word <= pf_word;
                        pf_vld   <= land;
                        pf_word  <= land ? data_dfx_recv : '0;
                    end else if (land) begin
                        out_vld  <= 1'b1;
                        out_word <= data_dfx_recv;
                    end else begin
                        out_vld  <= 1'b0;
                        out_word <= '0;
                    end
                end else if (land) begin
                    pf_vld  <= 1'b1;
                    pf_word <= data_dfx_recv;
                end
            end
        end
    end

endmodule
